// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with single-cycle logic/arith/shift ops, Booth MUL and restoring DIV.
// Latency: single-cycle ops and DIV-by-zero 1 clk start->done; MUL/DIV WIDTH+1 clks.
// Backpressure: start is only accepted when busy==0 (IDLE or DONE); starts while busy are dropped.
//
// Ports:
//   clk, clear_n          clock, synchronous active-low reset
//   start, op, A, B       launch handshake, opcode and operands (sampled together)
//   busy, done            multi-cycle op in progress / one-cycle result-valid pulse
//   result_lo, result_hi  low word or quotient / high word or remainder (held between dones)
//   carry_out, div_zero, illegal_op  status flags for the last completed op
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             div_zero,
  output logic             illegal_op
);

  localparam int CW = SHW + 1;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_DIV  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_MUL  = 6'd6;
  localparam logic [5:0] OP_SHR  = 6'd7;
  localparam logic [5:0] OP_SHL  = 6'd8;
  localparam logic [5:0] OP_ROR  = 6'd9;
  localparam logic [5:0] OP_ROL  = 6'd10;
  localparam logic [5:0] OP_NEG  = 6'd11;
  localparam logic [5:0] OP_NOT  = 6'd12;
  localparam logic [5:0] OP_SHRA = 6'd13;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc is one bit wider than the operand: Booth's add/sub of the most-negative
  // multiplicand would otherwise overflow, and DIV uses it as the partial remainder.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;        // multiplier (MUL) / dividend-then-quotient (DIV)
  logic             qm1_q, qm1_d;    // Booth Q[-1]
  logic [WIDTH:0]   m_q, m_d;        // sign-extended multiplicand / zero-extended divisor
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             carry_q, carry_d;
  logic             dz_q, dz_d;
  logic             ill_q, ill_d;

  // Single-cycle datapath
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [WIDTH-1:0] ror_v, rol_v;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign amt     = A[SHW-1:0];
  assign sum_add = {1'b0, A} + {1'b0, B};
  // B - A as B + ~A + 1: the carry out of bit WIDTH is the not-borrow (B >= A).
  assign sum_sub = {1'b0, B} + {1'b0, ~A} + {{WIDTH{1'b0}}, 1'b1};
  // A shift by WIDTH yields zero, so amt==0 passes B unchanged.
  assign ror_v   = (B >> amt) | (B << (WIDTH - int'(amt)));
  assign rol_v   = (B << amt) | (B >> (WIDTH - int'(amt)));
  assign abs_a   = A[WIDTH-1] ? -A : A;
  assign abs_b   = B[WIDTH-1] ? -B : B;

  // Booth step: add/sub M per {Q0,Q-1}, then arithmetic shift of {acc,Q,Q-1}
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc;
  logic [WIDTH-1:0] booth_q;

  always_comb begin
    booth_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase
  end

  assign booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_q   = {booth_sum[0], q_q[WIDTH-1:1]};

  // Restoring divide step on magnitudes: shift in next dividend bit, trial-subtract divisor.
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_diff;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] div_q;

  assign r_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign r_diff  = r_shift - m_q;
  assign div_r   = r_diff[WIDTH] ? r_shift[WIDTH-1:0] : r_diff[WIDTH-1:0];
  assign div_q   = {q_q[WIDTH-2:0], ~r_diff[WIDTH]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    carry_d = carry_q;
    dz_d    = dz_q;
    ill_d   = ill_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_DONE;
          carry_d = 1'b0;
          dz_d    = 1'b0;
          ill_d   = 1'b0;
          hi_d    = '0;
          case (op)
            OP_ADD:  {carry_d, lo_d} = sum_add;
            OP_SUB:  {carry_d, lo_d} = sum_sub;
            OP_AND:  lo_d = A & B;
            OP_OR:   lo_d = A | B;
            OP_XOR:  lo_d = A ^ B;
            OP_SHR:  lo_d = B >> amt;
            OP_SHL:  lo_d = B << amt;
            OP_ROR:  lo_d = ror_v;
            OP_ROL:  lo_d = rol_v;
            OP_NEG:  lo_d = -A;
            OP_NOT:  lo_d = ~A;
            OP_SHRA: lo_d = $signed(B) >>> amt;
            OP_MUL: begin
              // Results keep their previous value until the multi-cycle op completes.
              state_d = S_MUL;
              hi_d    = hi_q;
              acc_d   = '0;
              q_d     = B;
              qm1_d   = 1'b0;
              m_d     = {A[WIDTH-1], A};
              cnt_d   = CW'(WIDTH);
            end
            OP_DIV: begin
              if (B == '0) begin
                dz_d = 1'b1;
                lo_d = '1;
                hi_d = A;
              end else begin
                state_d = S_DIV;
                hi_d    = hi_q;
                acc_d   = '0;
                q_d     = abs_a;
                m_d     = {1'b0, abs_b};
                qneg_d  = A[WIDTH-1] ^ B[WIDTH-1];
                rneg_d  = A[WIDTH-1];
                cnt_d   = CW'(WIDTH);
              end
            end
            default: begin
              ill_d = 1'b1;
              lo_d  = '0;
            end
          endcase
        end
      end

      S_MUL: begin
        acc_d = booth_acc;
        q_d   = booth_q;
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d      = S_DONE;
          {hi_d, lo_d} = {booth_acc[WIDTH-1:0], booth_q};
        end
      end

      S_DIV: begin
        acc_d = {1'b0, div_r};
        q_d   = div_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          lo_d    = qneg_q ? -div_q : div_q;
          hi_d    = rneg_q ? -div_r : div_r;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
    end
  end

  assign busy       = (state_q == S_MUL) || (state_q == S_DIV);
  assign done       = (state_q == S_DONE);
  assign result_lo  = lo_q;
  assign result_hi  = hi_q;
  assign carry_out  = carry_q;
  assign div_zero   = dz_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized + directed stimulus for seq_alu with a queue scoreboard.
// Expected results come from a plain-arithmetic reference model (64-bit integer math).
// A separate monitor pops and compares on every done pulse, including the completion cycle.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clear_n;
  logic         start;
  logic [5:0]   op;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] result_lo, result_hi;
  logic         carry_out, div_zero, illegal_op;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .start      (start),
    .op         (op),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .carry_out  (carry_out),
    .div_zero   (div_zero),
    .illegal_op (illegal_op)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        c;
    logic        dz;
    logic        ill;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model: straight from the opcode definitions, using wide integer arithmetic.
  function automatic exp_t model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      p, qt, rm;
    logic [32:0] s;
    logic [31:0] x;
    int          sh;
    e.lo = '0; e.hi = '0; e.c = 1'b0; e.dz = 1'b0; e.ill = 1'b0; e.due = 0;
    sh = int'(a[4:0]);
    x  = b;
    case (o)
      6'd0: begin s = {1'b0, a} + {1'b0, b}; e.lo = s[31:0]; e.c = s[32]; end
      6'd1: begin e.lo = b - a; e.c = (b >= a); end
      6'd2: begin
        if (b == 0) begin
          e.dz = 1'b1; e.lo = 32'hFFFF_FFFF; e.hi = a;
        end else begin
          qt = longint'($signed(a)) / longint'($signed(b));
          rm = longint'($signed(a)) % longint'($signed(b));
          e.lo = qt[31:0]; e.hi = rm[31:0];
        end
      end
      6'd3: e.lo = a & b;
      6'd4: e.lo = a | b;
      6'd5: e.lo = a ^ b;
      6'd6: begin p = longint'($signed(a)) * longint'($signed(b)); {e.hi, e.lo} = p; end
      6'd7: e.lo = b >> sh;
      6'd8: e.lo = b << sh;
      6'd9:  begin repeat (sh) x = {x[0], x[31:1]}; e.lo = x; end
      6'd10: begin repeat (sh) x = {x[30:0], x[31]}; e.lo = x; end
      6'd11: e.lo = -a;
      6'd12: e.lo = ~a;
      6'd13: e.lo = $signed(b) >>> sh;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (clear_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("result_lo",  64'(result_lo),  64'(mon_e.lo));
        check("result_hi",  64'(result_hi),  64'(mon_e.hi));
        check("carry_out",  64'(carry_out),  64'(mon_e.c));
        check("div_zero",   64'(div_zero),   64'(mon_e.dz));
        check("illegal_op", 64'(illegal_op), 64'(mon_e.ill));
        check("done_cycle", 64'(cyc),        64'(mon_e.due));
        check("busy_at_done", 64'(busy),     64'(0));
      end
    end
  end

  // Issue one op and wait for its done. With poke set, an ADD start is pulsed mid-operation
  // and must be ignored. The next issue starts in the DONE cycle (back-to-back).
  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    exp_t e;
    int   lat, nb, k;
    e   = model(o, a, b);
    lat = (o == 6'd6 || (o == 6'd2 && b != 0)) ? 33 : 1;
    e.due = cyc + lat;
    sb.push_back(e);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (lat > 1) check("flags_cleared", 64'({carry_out, div_zero, illegal_op}), 64'(0));
    nb = 0; k = 0;
    while (!done && k < 100) begin
      if (busy) nb++;
      if (poke && k == 5) begin
        start = 1'b1; op = 6'd0; A = $urandom; B = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (k >= 100) check("done_timeout", 64'(k), 64'(0));
    check("busy_cycles", 64'(nb), 64'(lat - 1));
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      4: return -32'($urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] ro;
    clear_n = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_lo",   64'(result_lo), 64'(0));
    check("rst_hi",   64'(result_hi), 64'(0));
    check("rst_flags", 64'({carry_out, div_zero, illegal_op}), 64'(0));
    clear_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases
    issue(6'd0,  32'hFFFF_FFFF, 32'h1, 1'b0);
    issue(6'd1,  32'd5, 32'd3, 1'b0);
    issue(6'd6,  -32'd7, 32'd6, 1'b0);
    issue(6'd6,  32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(6'd2,  -32'd17, 32'd5, 1'b0);
    issue(6'd2,  32'd9, 32'd0, 1'b0);
    issue(6'd9,  32'd1, 32'h0000_0001, 1'b0);
    issue(6'd10, 32'd33, 32'h1234_5678, 1'b0);
    issue(6'd13, 32'd4, 32'h8000_0000, 1'b0);
    issue(6'd12, 32'd0, 32'h5555_5555, 1'b0);
    issue(6'd63, 32'h1, 32'h2, 1'b0);
    issue(6'd8,  32'd0, 32'hCAFE_F00D, 1'b0);
    issue(6'd2,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(6'd6,  32'h1234_5678, -32'd3, 1'b1);
    issue(6'd2,  32'd1000, -32'd7, 1'b1);

    // Reset during a DIV: aborts with no done pulse
    start = 1'b1; op = 6'd2; A = -32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clear_n = 1'b0;
    @(posedge clk); #1;
    clear_n = 1'b1;
    check("abort_busy",  64'(busy), 64'(0));
    check("abort_done",  64'(done), 64'(0));
    check("abort_lo",    64'(result_lo), 64'(0));
    check("abort_hi",    64'(result_hi), 64'(0));
    check("abort_flags", 64'({carry_out, div_zero, illegal_op}), 64'(0));
    repeat (40) @(posedge clk);
    #1;

    // Randomized ops
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 15) == 0) ro = 6'($urandom_range(14, 63));
      else                            ro = 6'($urandom_range(0, 13));
      issue(ro, rnd_opnd(), rnd_opnd(), ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
